// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and load results onto one register-file write port with an in-order load queue.
module writeback_arbiter #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [REG_AW-1:0] load_reg,
  input  logic [DATA_W-1:0] load_data,
  output logic              regWrite,
  output logic [REG_AW-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  input  logic [REG_AW-1:0] pend_query_reg,
  output logic              pend_hit,
  output logic [DATA_W-1:0] pend_data,
  output logic              busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [REG_AW-1:0] reg_q [FIFO_DEPTH];
  logic [DATA_W-1:0] data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live_q;
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0] count_q;
  logic regwrite_q;
  logic [REG_AW-1:0] writereg_q;
  logic [DATA_W-1:0] writedata_q;
  logic accept, alu_iss, nonempty, head_iss, pop, bypass, push;
  assign load_ready = !rst && (count_q < (PW+1)'(FIFO_DEPTH));
  assign accept     = load_valid && load_ready;
  assign alu_iss    = alu_valid && alu_reg != '0;
  assign nonempty   = count_q != '0;
  assign head_iss   = !alu_iss && nonempty && live_q[head_q];
  // a dead head is dropped even while the ALU owns the port
  assign pop        = nonempty && (!live_q[head_q] || !alu_iss);
  assign bypass     = !alu_iss && !nonempty && accept && load_reg != '0;
  assign push       = accept && load_reg != '0 && !bypass;
  assign busy       = |live_q;
  assign regWrite   = regwrite_q;
  assign writeReg   = writereg_q;
  assign writeData  = writedata_q;
  always_comb begin
    pend_hit  = 1'b0;
    pend_data = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (pend_query_reg != '0 && live_q[head_q + PW'(i)] && reg_q[head_q + PW'(i)] == pend_query_reg) begin
        pend_hit  = 1'b1;
        pend_data = data_q[head_q + PW'(i)];
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (alu_iss)
        for (int i = 0; i < FIFO_DEPTH; i++)
          if (reg_q[i] == alu_reg) live_q[i] <= 1'b0;
      if (pop) begin
        live_q[head_q] <= 1'b0;
        head_q         <= head_q + PW'(1);
      end
      // the pushed entry is younger than any same-cycle ALU write, so it stays live
      if (push) begin
        reg_q[tail_q]  <= load_reg;
        data_q[tail_q] <= load_data;
        live_q[tail_q] <= 1'b1;
        tail_q         <= tail_q + PW'(1);
      end
      count_q     <= count_q + (PW+1)'(push) - (PW+1)'(pop);
      regwrite_q  <= alu_iss || head_iss || bypass;
      writereg_q  <= alu_iss ? alu_reg : head_iss ? reg_q[head_q] : bypass ? load_reg : '0;
      writedata_q <= alu_iss ? alu_data : head_iss ? data_q[head_q] : bypass ? load_data : '0;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed scenario bench for writeback_arbiter with a register-file model.
module tb_writeback_arbiter;
  logic clk = 1'b0, rst;
  logic alu_valid, load_valid, load_ready, regWrite, pend_hit, busy;
  logic [2:0] alu_reg, load_reg, writeReg, pend_query_reg;
  logic [15:0] alu_data, load_data, writeData, pend_data;
  int checks = 0, failures = 0;
  logic [15:0] rf [8];
  bit saw_aaaa = 0, saw_r0 = 0, saw_flushed = 0;

  writeback_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .load_valid(load_valid), .load_ready(load_ready), .load_reg(load_reg), .load_data(load_data),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .pend_query_reg(pend_query_reg), .pend_hit(pend_hit), .pend_data(pend_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (regWrite) rf[writeReg] <= writeData;
    if (regWrite && writeReg == 3'd4 && writeData == 16'hAAAA) saw_aaaa <= 1'b1;
    if (regWrite && writeReg == 3'd0) saw_r0 <= 1'b1;
    if (regWrite && (writeData == 16'hD00D || writeData == 16'hF00D)) saw_flushed <= 1'b1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_reg = 0; alu_data = 0;
    load_valid = 0; load_reg = 0; load_data = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); pend_query_reg = 0;
    #1;
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", load_ready); end
    cyc(); cyc();
    checks++; if (regWrite !== 1'b0 || writeReg !== 3'd0 || writeData !== 16'h0) begin failures++; $display("FAIL reset_out got=%b/%0d/%h exp=0/0/0000", regWrite, writeReg, writeData); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 0;
    alu_valid = 1; alu_reg = 3; alu_data = 16'h1234;
    #1;
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", load_ready); end
    cyc(); idle();
    checks++; if (regWrite !== 1'b1 || writeReg !== 3'd3 || writeData !== 16'h1234) begin failures++; $display("FAIL alu_first got=%b/%0d/%h exp=1/3/1234", regWrite, writeReg, writeData); end
  endtask

  task automatic test_bypass();
    load_valid = 1; load_reg = 5; load_data = 16'hBEEF;
    cyc(); idle();
    checks++; if (regWrite !== 1'b1 || writeReg !== 3'd5 || writeData !== 16'hBEEF) begin failures++; $display("FAIL bypass got=%b/%0d/%h exp=1/5/beef", regWrite, writeReg, writeData); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bypass_busy got=%b exp=0", busy); end
  endtask

  task automatic test_same_cycle();
    alu_valid = 1; alu_reg = 1; alu_data = 16'h0001;
    load_valid = 1; load_reg = 2; load_data = 16'h0002;
    cyc(); idle(); pend_query_reg = 2; #1;
    checks++; if (regWrite !== 1'b1 || writeReg !== 3'd1 || writeData !== 16'h0001) begin failures++; $display("FAIL same_alu got=%b/%0d/%h exp=1/1/0001", regWrite, writeReg, writeData); end
    checks++; if (pend_hit !== 1'b1 || pend_data !== 16'h0002) begin failures++; $display("FAIL same_pend got=%b/%h exp=1/0002", pend_hit, pend_data); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL same_busy got=%b exp=1", busy); end
    cyc();
    checks++; if (regWrite !== 1'b1 || writeReg !== 3'd2 || writeData !== 16'h0002) begin failures++; $display("FAIL same_load got=%b/%0d/%h exp=1/2/0002", regWrite, writeReg, writeData); end
    checks++; if (busy !== 1'b0 || pend_hit !== 1'b0) begin failures++; $display("FAIL same_drained got=%b/%b exp=0/0", busy, pend_hit); end
    pend_query_reg = 0; #1;
    checks++; if (pend_hit !== 1'b0) begin failures++; $display("FAIL pend_r0 got=%b exp=0", pend_hit); end
  endtask

  task automatic test_kill();
    alu_valid = 1; alu_reg = 1; alu_data = 16'h0011;
    load_valid = 1; load_reg = 4; load_data = 16'hAAAA;
    cyc();
    alu_reg = 2; alu_data = 16'h0022;
    load_reg = 6; load_data = 16'hBBBB;
    cyc();
    pend_query_reg = 4; #1;
    checks++; if (pend_hit !== 1'b1 || pend_data !== 16'hAAAA) begin failures++; $display("FAIL kill_pre got=%b/%h exp=1/aaaa", pend_hit, pend_data); end
    load_valid = 0; alu_reg = 4; alu_data = 16'h5555;
    cyc(); idle();
    checks++; if (pend_hit !== 1'b0 || pend_data !== 16'h0) begin failures++; $display("FAIL kill_pend got=%b/%h exp=0/0000", pend_hit, pend_data); end
    pend_query_reg = 6; #1;
    checks++; if (pend_hit !== 1'b1 || pend_data !== 16'hBBBB) begin failures++; $display("FAIL kill_pend6 got=%b/%h exp=1/bbbb", pend_hit, pend_data); end
    cyc();
    checks++; if (regWrite !== 1'b0) begin failures++; $display("FAIL kill_dead_pop got=%b exp=0", regWrite); end
    cyc();
    checks++; if (regWrite !== 1'b1 || writeReg !== 3'd6 || writeData !== 16'hBBBB) begin failures++; $display("FAIL kill_r6 got=%b/%0d/%h exp=1/6/bbbb", regWrite, writeReg, writeData); end
    cyc();
    checks++; if (rf[4] !== 16'h5555 || rf[6] !== 16'hBBBB) begin failures++; $display("FAIL kill_rf got=%h/%h exp=5555/bbbb", rf[4], rf[6]); end
    checks++; if (saw_aaaa !== 1'b0) begin failures++; $display("FAIL kill_stale got=%b exp=0", saw_aaaa); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL kill_busy got=%b exp=0", busy); end
  endtask

  task automatic test_full();
    int acc = 0, drained = 0;
    logic [2:0] order [8];
    for (int c = 0; c < 20; c++) begin
      alu_valid = (c < 6); alu_reg = 7; alu_data = 16'h7000 + 16'(c);
      load_valid = (acc < 5); load_reg = 3'(acc + 1); load_data = 16'h0100 + 16'(acc);
      #1;
      if (c >= 4 && c <= 6) begin
        checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL full_ready_c%0d got=%b exp=0", c, load_ready); end
      end
      if (c == 7) begin
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL full_reopen got=%b exp=1", load_ready); end
      end
      if (load_valid && load_ready) acc++;
      if (c == 5) begin
        checks++; if (acc !== 4) begin failures++; $display("FAIL full_accepted got=%0d exp=4", acc); end
      end
      cyc();
      if (c < 6) begin
        checks++; if (regWrite !== 1'b1 || writeReg !== 3'd7 || writeData !== 16'h7000 + 16'(c)) begin failures++; $display("FAIL full_alu_c%0d got=%b/%0d/%h", c, regWrite, writeReg, writeData); end
      end else if (regWrite && drained < 8) begin
        order[drained] = writeReg; drained++;
      end
    end
    idle();
    checks++; if (drained !== 5) begin failures++; $display("FAIL full_drain_count got=%0d exp=5", drained); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (order[i] !== 3'(i + 1)) begin failures++; $display("FAIL full_order_%0d got=%0d exp=%0d", i, order[i], i + 1); end
    end
  endtask

  task automatic test_r0_and_reset();
    alu_valid = 1; alu_reg = 0; alu_data = 16'h0EEE;
    load_valid = 1; load_reg = 0; load_data = 16'h0FFF;
    #1;
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL r0_ready got=%b exp=1", load_ready); end
    cyc();
    checks++; if (regWrite !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL r0_both got=%b/%b exp=0/0", regWrite, busy); end
    load_reg = 3; load_data = 16'h0303;
    cyc(); idle();
    checks++; if (regWrite !== 1'b1 || writeReg !== 3'd3 || writeData !== 16'h0303) begin failures++; $display("FAIL r0_alu_load got=%b/%0d/%h exp=1/3/0303", regWrite, writeReg, writeData); end
    alu_valid = 1; alu_reg = 7; alu_data = 16'h0777;
    load_valid = 1; load_reg = 1; load_data = 16'hD00D;
    cyc();
    load_reg = 2; load_data = 16'hF00D;
    cyc(); idle();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL queued_busy got=%b exp=1", busy); end
    rst = 1;
    cyc();
    rst = 0;
    checks++; if (regWrite !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush got=%b/%b exp=0/0", regWrite, busy); end
    for (int i = 0; i < 6; i++) cyc();
    checks++; if (saw_flushed !== 1'b0) begin failures++; $display("FAIL flushed_write got=%b exp=0", saw_flushed); end
    checks++; if (saw_r0 !== 1'b0) begin failures++; $display("FAIL r0_write got=%b exp=0", saw_r0); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_same_cycle();
    test_kill();
    test_full();
    test_r0_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Write-side driver for the 8x16-bit register file write port (regWrite/writeReg/writeData). It merges two result producers, the single-cycle ALU and the variable-latency load unit, onto the one write port.
- ALU results always win the port.
- Load results wait in a small in-order FIFO.
- Stale queued loads are killed when a younger ALU write targets the same register.
- A pending-write query port lets decode see results not yet written.

Parameters:
DATA_W, 16, register data width
REG_AW, 3, register index width (8 registers, r0 hardwired zero)
FIFO_DEPTH, 4, load-result queue entries (power of two, >=2)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
alu_valid  in  1  ALU result present this cycle (no backpressure, always accepted)
alu_reg  in  REG_AW  ALU destination register
alu_data  in  DATA_W  ALU result
load_valid  in  1  load result offered
load_ready  out  1  load result accepted this cycle when load_valid && load_ready
load_reg  in  REG_AW  load destination register
load_data  in  DATA_W  load result
regWrite  out  1  register file write enable (registered)
writeReg  out  REG_AW  register file write index (registered)
writeData  out  DATA_W  register file write data (registered)
pend_query_reg  in  REG_AW  register index to check for a pending write
pend_hit  out  1  a queued, live load write to pend_query_reg exists (combinational)
pend_data  out  DATA_W  data of the youngest live matching entry (0 when no hit)
busy  out  1  FIFO holds at least one live entry

Behaviour:
- Reset (rst high at a clk edge):
  - regWrite=0, writeReg=0, writeData=0.
  - FIFO empty, all entries dead, pointers 0, count 0.
  - load_ready=0 while rst is high.
  - Any in-flight queued load is discarded.
- Output latency: exactly 1 cycle. The write chosen in cycle N appears on regWrite/writeReg/writeData after edge N and is written by the register file at edge N+1.
- Per-cycle port selection, evaluated at each edge:
  1. If alu_valid && alu_reg!=0: the ALU write is issued.
  2. Else, if the FIFO head is live: the head is issued and popped.
  3. Else, if the FIFO is empty and a load handshake occurs with load_reg!=0: the load bypasses the FIFO and is issued directly.
  4. Else: regWrite=0.
- Dead FIFO head: popped without issuing, even in a cycle where the ALU owns the port.
- Load acceptance:
  - load_ready = !rst && (count < FIFO_DEPTH).
  - A load accepted and not bypassed is pushed at the tail as live.
  - Push and pop may occur in the same cycle; count is unchanged.
  - A load with load_reg==0 is accepted but neither pushed nor issued.
- r0 writes: never produce regWrite=1.
- Ordering kill: when an ALU write to register R is issued, every live FIFO entry with reg==R is marked dead in the same edge. This guarantees the younger ALU value is not overwritten by an older load.
  - A load accepted in that same cycle for R is younger than the ALU result and is not killed.
- Pending query:
  - Scans live FIFO entries and returns the youngest match (closest to tail).
  - pend_query_reg==0 always gives pend_hit=0.
  - The registered output stage is not included in the scan; decode covers that stage through its own forwarding.
- busy = any live entry in the FIFO.
- Full boundary: with count==FIFO_DEPTH, load_ready=0. If the head pops in that cycle, load_ready stays 0 for that cycle (ready does not depend on the pop).
- Pointer wrap: modulo FIFO_DEPTH; count is kept separately so full and empty are distinguishable.

Test Plan:
1. Reset, then ALU r3=0x1234 in cycle 0 -> regWrite=1, writeReg=3, writeData=0x1234 after edge 0. load_ready=0 during rst and 1 afterward.
2. Load r5=0xBEEF alone with empty FIFO -> bypass, regWrite=1, writeReg=5 next cycle, busy stays 0.
3. ALU r1=0x0001 and load r2=0x0002 in the same cycle -> cycle+1 writes r1, cycle+2 writes r2. pend_hit=1 for query r2 during cycle+1 with pend_data=0x0002.
4. Queue loads r4=0xAAAA and r6=0xBBBB under continuous ALU traffic, then ALU r4=0x5555 -> the r4 load is killed, the final register file has r4=0x5555 and r6=0xBBBB, and no regWrite with writeReg=4/0xAAAA ever appears.
5. Hold alu_valid=1 for 6 cycles while offering 5 loads -> exactly 4 accepted, load_ready=0 on the 5th. After the ALU stops, 4 writes drain in order, then the 5th load is accepted.
6. Writes to r0 from both sources, plus rst asserted while 2 entries are queued -> no regWrite for r0. After rst, busy=0, regWrite=0, and the queued writes never appear.
